pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Parametrised pipeline control unit; successor to the hand-wired stall/flush/valid logic in the 5-stage MIPS core.
- Generates per-stage stall and flush, tracks a valid bit and a side-band tag per stage, and reports retirement at the last stage.
- Sits beside the datapath. Each pipeline register uses stall_o[k] as its hold and flush_o[k] as its synchronous clear.
- Replaces per-signal tag flops (e.g. the fetch-stall marker carried down to writeback).

Parameters:
- NSTAGE, 5, number of pipeline stages; stage 0 is the youngest (F) and NSTAGE-1 the oldest (W); legal range 2..8.
- TAG_W, 1, width of the side-band tag carried with each instruction.
- CNT_W, 32, width of the performance counters (used only with PIPE_PERF_CNT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_valid_i  in  1  a valid instruction enters stage 0 at this edge
- if_tag_i  in  TAG_W  tag for the entering instruction
- stallreq_i  in  NSTAGE  per-stage stall request (memory, mult/div, ifetch)
- kill_younger_i  in  NSTAGE  bit m squashes all stages with index < m (branch/jump redirect)
- excflush_i  in  1  exception or eret: squash every stage
- stall_o  out  NSTAGE  per-stage hold
- flush_o  out  NSTAGE  per-stage clear at the next edge
- valid_o  out  NSTAGE  stage holds a live instruction
- tag_o  out  NSTAGE*TAG_W  per-stage tag; stage k occupies bits [k*TAG_W +: TAG_W]
- retire_o  out  1  the instruction in stage NSTAGE-1 completes at this edge
- retire_tag_o  out  TAG_W  tag of the retiring instruction
- cnt_clr_i  in  1  synchronous clear of the performance counters
- retire_cnt_o  out  CNT_W  retired-instruction count
- stall_cnt_o  out  CNT_W  cycles with stall_o[0] high

Behaviour:
- Reset is asynchronous, active-high. During reset: valid, tag and counter registers are all 0, so valid_o = 0, tag_o = 0 and retire_o = 0.
- Stall: stall_o[k] = OR of stallreq_i[NSTAGE-1:k]. A stall in any stage backs up every younger stage.
- Squash: squash[k] = OR of kill_younger_i[NSTAGE-1:k+1]. squash[NSTAGE-1] = 0.
- excflush_i has top priority:
  - stall_o = 0 and flush_o = all 1.
  - At the next edge every valid and tag clears to 0, even while stall requests are pending.
- Without excflush_i, flush_o[k] = (stall_o[k] & squash[k]) | (k>0 & ~stall_o[k] & (stall_o[k-1] | squash[k-1])).
  - The first term squashes a stalled, killed stage.
  - The second term inserts a bubble below a stalled or squashed stage.
- Next-state rule for stage k, in priority order:
  1. excflush_i: valid cleared to 0.
  2. flush_o[k]: valid cleared to 0.
  3. stall_o[k]: valid and tag held.
  4. k = 0: load if_valid_i and if_tag_i. The redirect target is never squashed by its own kill.
  5. Otherwise: load valid and tag from stage k-1.
- Tag of an invalid stage is 0.
- Latency: with no stalls, an instruction accepted at edge t is in stage k after edge t+k.
- retire_o = valid_o[NSTAGE-1] & ~stall_o[NSTAGE-1] & ~excflush_i.
- retire_tag_o = tag of stage NSTAGE-1 when retire_o is high, else 0.
- kill_younger_i[0] has no effect.
- Simultaneous kill bits: the OR is used, so the oldest requester dominates.
- Reset asserted mid-stall clears all state immediately; stall_o and flush_o remain purely combinational from the inputs.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - retire_cnt_o increments on each retire_o.
  - stall_cnt_o increments on each cycle with stall_o[0] high and excflush_i low.
  - Both counters saturate at all-ones.
  - cnt_clr_i clears both, with priority over increment.
- Undefined: no counter flops; retire_cnt_o and stall_cnt_o tie to 0; cnt_clr_i is ignored.

Decomposition:
- Package pipe_pkg:
  - stage index constants STG_F=0, STG_D=1, STG_E=2, STG_M=3, STG_W=4;
  - PIPE_NSTAGE_DEF=5;
  - a function or_above(vec, k) returning the OR of bits k..top, used for the stall and squash chains.
- Sub-module pipe_ctrl_stage: one valid+tag register with the priority rule above, instantiated NSTAGE times by a generate loop.
- The top level holds only the combinational stall/flush chains, retire logic and the optional counters.

Test Plan:
- Free flow: NSTAGE=5; assert if_valid_i for 3 cycles with tags 1,0,1 -> retire_o high at edges 4,5,6; retire_tag_o = 1,0,1.
- Memory stall: stallreq_i[3] held high 2 cycles with stages 0..3 valid:
  - stall_o = 5'b01111, flush_o = 5'b10000;
  - valid_o[4] = 0 for those 2 cycles; no instruction is lost or duplicated.
- Branch redirect: kill_younger_i[1] pulse with stage 0 valid:
  - flush_o[1] = 1 and valid_o[1] = 0 next cycle;
  - the new if_valid_i instruction appears in stage 0.
- Exception with stall: excflush_i=1 with stallreq_i[2]=1 and all stages valid:
  - stall_o = 0, flush_o = 5'b11111, retire_o = 0;
  - all valid_o = 0 next cycle.
- Async reset mid-operation: rst pulse between clock edges -> valid_o and tag_o go to 0 immediately, without waiting for a clock edge.
- PIPE_PERF_CNT_EN with CNT_W=4:
  - 20 retires -> retire_cnt_o saturates at 15;
  - cnt_clr_i coinciding with a retire -> counter reads 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline control unit.
// Stage indices follow the classic F/D/E/M/W naming, youngest first.
package pipe_pkg;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

  localparam int PIPE_NSTAGE_DEF = 5;
  localparam int PIPE_NSTAGE_MAX = 8;

  // OR of vec[top:k]; k beyond the top returns 0
  function automatic logic or_above(input logic [PIPE_NSTAGE_MAX-1:0] vec, input int k);
    logic r;
    r = 1'b0;
    for (int i = 0; i < PIPE_NSTAGE_MAX; i++) begin
      r = r | (vec[i] & (i >= k));
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stage.sv
// One pipeline stage's valid bit and side-band tag.
// Priority: exception clear, flush clear, stall hold, load from the younger neighbour.
module pipe_ctrl_stage
  import pipe_pkg::*;
#(
  parameter int TAG_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_exc,
  input  logic             i_flush,
  input  logic             i_stall,
  input  logic             i_load_valid,
  input  logic [TAG_W-1:0] i_load_tag,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag
);

  logic             r_valid;
  logic [TAG_W-1:0] r_tag;

  // valid/tag register; an empty stage always carries tag 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else if (i_exc || i_flush) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else if (i_stall) begin
      r_valid <= r_valid;
      r_tag   <= r_tag;
    end else begin
      r_valid <= i_load_valid;
      r_tag   <= i_load_valid ? i_load_tag : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_tag   = r_tag;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage stall/flush chains, valid/tag tracking, retirement.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGE = PIPE_NSTAGE_DEF,
  parameter int TAG_W  = 1,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_valid_i,
  input  logic [TAG_W-1:0]        if_tag_i,
  input  logic [NSTAGE-1:0]       stallreq_i,
  input  logic [NSTAGE-1:0]       kill_younger_i,
  input  logic                    excflush_i,
  output logic [NSTAGE-1:0]       stall_o,
  output logic [NSTAGE-1:0]       flush_o,
  output logic [NSTAGE-1:0]       valid_o,
  output logic [NSTAGE*TAG_W-1:0] tag_o,
  output logic                    retire_o,
  output logic [TAG_W-1:0]        retire_tag_o,
  input  logic                    cnt_clr_i,
  output logic [CNT_W-1:0]        retire_cnt_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);

  logic [PIPE_NSTAGE_MAX-1:0] w_req_ext;
  logic [PIPE_NSTAGE_MAX-1:0] w_kill_ext;
  logic [NSTAGE-1:0]          w_stall_raw;
  logic [NSTAGE-1:0]          w_squash;
  logic [NSTAGE-1:0]          w_stall;
  logic [NSTAGE-1:0]          w_flush;
  logic [NSTAGE-1:0]          w_valid;
  logic [NSTAGE*TAG_W-1:0]    w_tag;
  logic [NSTAGE-1:0]          w_prev_valid;
  logic [NSTAGE*TAG_W-1:0]    w_prev_tag;
  logic                       w_retire;

  assign w_req_ext  = PIPE_NSTAGE_MAX'(stallreq_i);
  assign w_kill_ext = PIPE_NSTAGE_MAX'(kill_younger_i);

  // stall/squash chains and the resulting per-stage hold and clear
  always_comb begin
    w_stall_raw = '0;
    w_squash    = '0;
    w_stall     = '0;
    w_flush     = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      w_stall_raw[k] = or_above(w_req_ext, k);
      w_squash[k]    = or_above(w_kill_ext, k + 1);
    end
    if (excflush_i) begin
      w_stall = '0;
      w_flush = '1;
    end else begin
      w_stall    = w_stall_raw;
      w_flush[0] = w_stall_raw[0] & w_squash[0];
      // a stage moving on while its younger neighbour is held or killed receives a bubble
      for (int k = 1; k < NSTAGE; k++) begin
        w_flush[k] = (w_stall_raw[k] & w_squash[k]) |
                     (~w_stall_raw[k] & (w_stall_raw[k-1] | w_squash[k-1]));
      end
    end
  end

  assign w_prev_valid = {w_valid[NSTAGE-2:0], if_valid_i};
  assign w_prev_tag   = {w_tag[(NSTAGE-1)*TAG_W-1:0], if_tag_i};

  for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
    pipe_ctrl_stage #(
      .TAG_W (TAG_W)
    ) u_stage (
      .clk          (clk),
      .rst          (rst),
      .i_exc        (excflush_i),
      .i_flush      (w_flush[g]),
      .i_stall      (w_stall[g]),
      .i_load_valid (w_prev_valid[g]),
      .i_load_tag   (w_prev_tag[g*TAG_W +: TAG_W]),
      .o_valid      (w_valid[g]),
      .o_tag        (w_tag[g*TAG_W +: TAG_W])
    );
  end

  assign w_retire     = w_valid[NSTAGE-1] & ~w_stall[NSTAGE-1] & ~excflush_i;
  assign retire_o     = w_retire;
  assign retire_tag_o = w_retire ? w_tag[(NSTAGE-1)*TAG_W +: TAG_W] : '0;

  assign stall_o = w_stall;
  assign flush_o = w_flush;
  assign valid_o = w_valid;
  assign tag_o   = w_tag;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // saturating retire and front-end stall counters; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
    end else if (cnt_clr_i) begin
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_retire && (r_retire_cnt != '1)) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
      if (w_stall[STG_F] && !excflush_i && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign retire_cnt_o = r_retire_cnt;
  assign stall_cnt_o  = r_stall_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr_i;
  assign retire_cnt_o     = '0;
  assign stall_cnt_o      = '0;
`endif

endmodule
